// File: rtl/sensor_framer_pkg.sv
// ---------------------------------------------------------------------------
// sensor_framer_pkg
// Shared types and constants for the sensor ASCII framer.
//   framer_state_t : framer FSM states (also exported on the debug port)
//   ASCII_*        : byte values placed on the UART TX interface
// ---------------------------------------------------------------------------
package sensor_framer_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CONVERT    = 3'd1,
    SEND_DIGIT = 3'd2,
    SEND_CR    = 3'd3,
    SEND_LF    = 3'd4
  } framer_state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

endpackage

// File: rtl/bcd_seq_converter.sv
// ---------------------------------------------------------------------------
// bcd_seq_converter
// Sequential binary-to-BCD converter (shift-add-3 / double dabble).
// A start pulse latches bin and clears the BCD accumulator; the engine then
// runs exactly DATA_W steps. done pulses for one cycle after the last step,
// and bcd then holds the result until the next start.
//
// Ports:
//   clk   : clock
//   rst   : asynchronous active-low reset
//   start : load bin and begin a conversion (ignored cycles are harmless)
//   bin   : binary value, sampled when start is high
//   done  : one-cycle pulse, bcd is valid from this cycle on
//   bcd   : packed BCD result, nibble 0 = units
// ---------------------------------------------------------------------------
module bcd_seq_converter #(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0]   bin_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [4*DIGITS-1:0] adj;
  logic [CNT_W-1:0]    cnt;
  logic                run;
  logic                done_q;

  // Add 3 to every nibble >= 5 before the shift; 4-bit add, no carry out.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt    <= '0;
      run    <= 1'b0;
      done_q <= 1'b0;
    end else if (start) begin
      bin_q  <= bin;
      bcd_q  <= '0;
      cnt    <= CNT_W'(DATA_W);
      run    <= 1'b1;
      done_q <= 1'b0;
    end else if (run) begin
      {bcd_q, bin_q} <= {adj, bin_q} << 1;
      cnt            <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) begin
        run    <= 1'b0;
        done_q <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/sensor_ascii_framer.sv
// ---------------------------------------------------------------------------
// sensor_ascii_framer
// Takes one binary sensor sample, converts it to decimal and sends it to the
// UART transmitter as ASCII digits followed by CR, LF.
//
// Handshakes (both sides): a transfer happens on a rising clock edge where
// valid and ready are both high. The producer holds valid and data stable
// until that edge; valid never drops without a transfer.
//
// Build option: define FRAMER_FIXED_WIDTH_EN to send leading zeros so every
// frame is DIGITS+2 bytes. Default build suppresses leading zeros (the units
// digit is always sent).
//
// Ports:
//   clk            : system clock
//   rst            : asynchronous active-low reset
//   sample_i       : binary sample
//   sample_valid_i : sample present
//   sample_ready_o : high only in IDLE
//   tx_data_o      : ASCII byte to UART TX
//   tx_valid_o     : tx_data_o valid
//   tx_ready_i     : UART TX accepts the byte
//   busy_o         : a frame is being converted or sent
//   overrun_o      : sample offered while not ready (sample dropped)
//   state_dbg_o    : current FSM state (framer_state_t encoding)
// ---------------------------------------------------------------------------
module sensor_ascii_framer
  import sensor_framer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              sample_valid_i,
  output logic              sample_ready_o,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              busy_o,
  output logic              overrun_o,
  output logic [2:0]        state_dbg_o
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (64'd10 ** DIGITS <= (64'd1 << DATA_W) - 64'd1) begin : g_digits_check
    $error("sensor_ascii_framer: DIGITS too small for DATA_W");
  end

  framer_state_t       state, state_n;
  logic [IDX_W-1:0]    dig_idx, dig_idx_n;
  logic [IDX_W-1:0]    first_idx;
  logic                conv_start;
  logic                conv_done;
  logic [4*DIGITS-1:0] bcd;
  logic [3:0]          cur_nibble;

  bcd_seq_converter #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (sample_i),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // First digit to send: highest nonzero nibble (units if value is 0),
  // or always the top digit in the fixed-width build.
  always_comb begin
    first_idx = '0;
`ifdef FRAMER_FIXED_WIDTH_EN
    first_idx = IDX_W'(DIGITS - 1);
`else
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) begin
        first_idx = IDX_W'(i);
      end
    end
`endif
  end

  always_comb begin
    cur_nibble = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_idx == IDX_W'(i)) begin
        cur_nibble = bcd[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      dig_idx <= '0;
    end else begin
      state   <= state_n;
      dig_idx <= dig_idx_n;
    end
  end

  // Outputs are decoded from state, so an asynchronous reset clears
  // tx_valid_o/tx_data_o at once and no partial byte survives.
  always_comb begin
    state_n        = state;
    dig_idx_n      = dig_idx;
    conv_start     = 1'b0;
    sample_ready_o = 1'b0;
    tx_data_o      = 8'h00;
    tx_valid_o     = 1'b0;
    case (state)
      IDLE: begin
        sample_ready_o = 1'b1;
        if (sample_valid_i) begin
          conv_start = 1'b1;
          state_n    = CONVERT;
        end
      end
      CONVERT: begin
        if (conv_done) begin
          dig_idx_n = first_idx;
          state_n   = SEND_DIGIT;
        end
      end
      SEND_DIGIT: begin
        tx_data_o  = ASCII_ZERO + {4'h0, cur_nibble};
        tx_valid_o = 1'b1;
        if (tx_ready_i) begin
          if (dig_idx == '0) begin
            state_n = SEND_CR;
          end else begin
            dig_idx_n = dig_idx - 1'b1;
          end
        end
      end
      SEND_CR: begin
        tx_data_o  = ASCII_CR;
        tx_valid_o = 1'b1;
        if (tx_ready_i) begin
          state_n = SEND_LF;
        end
      end
      SEND_LF: begin
        tx_data_o  = ASCII_LF;
        tx_valid_o = 1'b1;
        if (tx_ready_i) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy_o      = (state != IDLE);
  assign overrun_o   = sample_valid_i && !sample_ready_o;
  assign state_dbg_o = state;

endmodule

// File: tb/tb_sensor_ascii_framer.sv
module tb_sensor_ascii_framer;

  logic       clk;
  logic       rst;
  logic [7:0] sample_i;
  logic       sample_valid_i;
  logic       sample_ready_o;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i;
  logic       busy_o;
  logic       overrun_o;
  logic [2:0] state_dbg_o;

  sensor_ascii_framer #(.DATA_W(8), .DIGITS(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .sample_ready_o (sample_ready_o),
    .tx_data_o      (tx_data_o),
    .tx_valid_o     (tx_valid_o),
    .tx_ready_i     (tx_ready_i),
    .busy_o         (busy_o),
    .overrun_o      (overrun_o),
    .state_dbg_o    (state_dbg_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #50 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  logic [7:0] exp_q[$];
  int  ready_mode = 0;   // 0: always ready, 1: random, 2: stall 5 cycles per byte
  int  acc_cyc    = 0;
  bit  lat_armed  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- tx_ready driver ----------------
  initial begin
    int stall = 0;
    tx_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: tx_ready_i = 1'b1;
        1: tx_ready_i = 1'($urandom_range(0, 1));
        default: begin
          if (!tx_valid_o) begin
            tx_ready_i = 1'b0;
            stall = 0;
          end else if (stall < 5) begin
            tx_ready_i = 1'b0;
            stall++;
          end else begin
            tx_ready_i = 1'b1;
            stall = 0;
          end
        end
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic       prev_valid = 0;
    logic       prev_ready = 0;
    logic [7:0] prev_data  = 0;
    bit         busy_next  = 0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (busy_next) begin
          chk("busy_after_lf", busy_o, 1'b0);
          busy_next = 0;
        end
        if (prev_valid && !prev_ready) begin
          chk("stall_valid_hold", tx_valid_o, 1'b1);
          chk("stall_data_hold", tx_data_o, prev_data);
        end
        if (lat_armed && tx_valid_o) begin
          chk("first_byte_latency", cyc - acc_cyc, 9);
          lat_armed = 0;
        end
        if (tx_valid_o && tx_ready_i) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_byte", tx_data_o, 8'hxx);
          end else begin
            e = exp_q.pop_front();
            chk("tx_byte", tx_data_o, e);
            if (e == 8'h0A) busy_next = 1;
          end
        end
        prev_valid = tx_valid_o;
        prev_ready = tx_ready_i;
        prev_data  = tx_data_o;
      end else begin
        prev_valid = 0;
        prev_ready = 0;
        busy_next  = 0;
        lat_armed  = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic offer(input logic [7:0] v);
    int n = 0;
    @(negedge clk);
    while (!sample_ready_o && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("offer_timeout", 0, 1);
    sample_i       = v;
    sample_valid_i = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc        = cyc;
    lat_armed      = 1;
    sample_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy_o) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic push_model(input int v);
`ifdef FRAMER_FIXED_WIDTH_EN
    exp_q.push_back(8'(8'h30 + v / 100));
    exp_q.push_back(8'(8'h30 + (v / 10) % 10));
`else
    if (v >= 100) exp_q.push_back(8'(8'h30 + v / 100));
    if (v >= 10)  exp_q.push_back(8'(8'h30 + (v / 10) % 10));
`endif
    exp_q.push_back(8'(8'h30 + v % 10));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst            = 1'b0;
    sample_i       = 8'h00;
    sample_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", tx_valid_o, 1'b0);
    chk("rst_tx_data", tx_data_o, 8'h00);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_overrun", overrun_o, 1'b0);
    chk("rst_state", state_dbg_o, 3'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_release_ready", sample_ready_o, 1'b1);

    // 123 with ready held high
    ready_mode = 0;
    exp_q.push_back(8'h31); exp_q.push_back(8'h32); exp_q.push_back(8'h33);
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    offer(8'd123);
    #1;
    chk("busy_in_convert", busy_o, 1'b1);
    chk("ready_in_convert", sample_ready_o, 1'b0);
    chk("valid_in_convert", tx_valid_o, 1'b0);
    wait_drain();

    // 7 and 0
`ifdef FRAMER_FIXED_WIDTH_EN
    exp_q.push_back(8'h30); exp_q.push_back(8'h30);
`endif
    exp_q.push_back(8'h37); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    offer(8'd7);
    wait_drain();
`ifdef FRAMER_FIXED_WIDTH_EN
    exp_q.push_back(8'h30); exp_q.push_back(8'h30);
`endif
    exp_q.push_back(8'h30); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    offer(8'd0);
    wait_drain();

    // 255 with 5-cycle stalls on each byte
    ready_mode = 2;
    exp_q.push_back(8'h32); exp_q.push_back(8'h35); exp_q.push_back(8'h35);
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    offer(8'd255);
    wait_drain();

    // 42 offered during conversion of 100: dropped with overrun pulse
    ready_mode = 0;
    exp_q.push_back(8'h31); exp_q.push_back(8'h30); exp_q.push_back(8'h30);
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    offer(8'd100);
    @(negedge clk);
    sample_i       = 8'd42;
    sample_valid_i = 1'b1;
    #1;
    chk("overrun_pulse", overrun_o, 1'b1);
    @(posedge clk);
    #1;
    sample_valid_i = 1'b0;
    #1;
    chk("overrun_clear", overrun_o, 1'b0);
    wait_drain();

    // reset while sending the second digit of 200
    ready_mode = 2;
    exp_q.push_back(8'h32);
    offer(8'd200);
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (exp_q.size() != 0 && n < 200);
    chk("first_digit_of_200", exp_q.size(), 0);
    chk("mid_frame_valid", tx_valid_o, 1'b1);
    rst = 1'b0;
    #1;
    chk("abort_tx_valid", tx_valid_o, 1'b0);
    chk("abort_tx_data", tx_data_o, 8'h00);
    chk("abort_busy", busy_o, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ready", sample_ready_o, 1'b1);
    ready_mode = 0;
    exp_q.push_back(8'h35); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    offer(8'd5);
    wait_drain();

    // back-to-back: new sample held valid across the LF handshake
    exp_q.push_back(8'h39); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    offer(8'd9);
    push_model(8);
    sample_i       = 8'd8;
    sample_valid_i = 1'b1;
    n = 0;
    while (state_dbg_o != 3'd4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("lf_cycle_overrun", overrun_o, 1'b1);
    chk("lf_cycle_ready", sample_ready_o, 1'b0);
    @(negedge clk);
    chk("idle_after_lf_ready", sample_ready_o, 1'b1);
    @(posedge clk);
    #1;
    sample_valid_i = 1'b0;
    wait_drain();

    // full sweep with random ready
    ready_mode = 1;
    for (int v = 0; v < 256; v++) begin
      push_model(v);
      offer(8'(v));
      wait_drain();
    end
    chk("queue_empty_end", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global time limit
  initial begin
    #50ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
